// File: rtl/sal_cmd_sched.sv
// Command-bus scheduler: picks at most one bank command per cycle, column commands first,
// enforcing tCCD and read/write turnaround, and registers the winner onto the command bus.
module sal_cmd_sched #(
    parameter int BK_CNT     = 4,
    parameter int BA_WIDTH   = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int TCCD       = 4,
    parameter int TRTW       = 6,
    parameter int TWTR       = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [BK_CNT-1:0]            req_valid,
    input  logic [2*BK_CNT-1:0]          req_cmd,
    input  logic [ADDR_WIDTH*BK_CNT-1:0] req_addr,
    output logic [BK_CNT-1:0]            req_ready,
    output logic                         cmd_valid,
    output logic [1:0]                   cmd_type,
    output logic [BA_WIDTH-1:0]          cmd_ba,
    output logic [ADDR_WIDTH-1:0]        cmd_addr
);

    typedef enum logic [1:0] {
        CMD_ACT = 2'd0,
        CMD_RD  = 2'd1,
        CMD_WR  = 2'd2,
        CMD_PRE = 2'd3
    } cmd_e;

    localparam int TMAX0 = (TCCD > TRTW) ? TCCD : TRTW;
    localparam int TMAX  = (TMAX0 > TWTR) ? TMAX0 : TWTR;
    localparam int CW    = (TMAX > 1) ? $clog2(TMAX) : 1;

    logic [CW-1:0]         ccd_q, ccd_d;
    logic [CW-1:0]         rd_blk_q, rd_blk_d;
    logic [CW-1:0]         wr_blk_q, wr_blk_d;
    logic [BA_WIDTH-1:0]   cas_ptr_q, cas_ptr_d;
    logic [BA_WIDTH-1:0]   ras_ptr_q, ras_ptr_d;
    logic                  cmd_valid_q, cmd_valid_d;
    logic [1:0]            cmd_type_q, cmd_type_d;
    logic [BA_WIDTH-1:0]   cmd_ba_q, cmd_ba_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;

    logic                  rd_ok, wr_ok;
    logic [BK_CNT-1:0]     cas_elig, ras_req;
    logic [BA_WIDTH:0]     cas_pick, ras_pick;
    logic                  gnt_valid, gnt_cas;
    logic [BA_WIDTH-1:0]   gnt_idx, gnt_nxt;
    logic [1:0]            gnt_type;
    logic [ADDR_WIDTH-1:0] gnt_addr;

    // Circular search from ptr; result is {found, index}.
    function automatic logic [BA_WIDTH:0] rr_pick(input logic [BK_CNT-1:0]   vec,
                                                  input logic [BA_WIDTH-1:0] ptr);
        logic [BA_WIDTH:0] res;
        int unsigned       idx;
        res = '0;
        for (int unsigned k = 0; k < BK_CNT; k++) begin
            idx = (32'(ptr) + k) % BK_CNT;
            if (!res[BA_WIDTH] && vec[idx[BA_WIDTH-1:0]]) begin
                res = {1'b1, idx[BA_WIDTH-1:0]};
            end
        end
        return res;
    endfunction

    always_comb begin
        rd_ok    = (ccd_q == '0) && (rd_blk_q == '0);
        wr_ok    = (ccd_q == '0) && (wr_blk_q == '0);
        cas_elig = '0;
        ras_req  = '0;
        for (int unsigned i = 0; i < BK_CNT; i++) begin
            cas_elig[i] = req_valid[i] &&
                          (((req_cmd[2*i +: 2] == CMD_RD) && rd_ok) ||
                           ((req_cmd[2*i +: 2] == CMD_WR) && wr_ok));
            ras_req[i]  = req_valid[i] &&
                          ((req_cmd[2*i +: 2] == CMD_ACT) || (req_cmd[2*i +: 2] == CMD_PRE));
        end
        cas_pick  = rr_pick(cas_elig, cas_ptr_q);
        ras_pick  = rr_pick(ras_req, ras_ptr_q);
        gnt_cas   = cas_pick[BA_WIDTH];
        gnt_valid = cas_pick[BA_WIDTH] | ras_pick[BA_WIDTH];
        gnt_idx   = gnt_cas ? cas_pick[BA_WIDTH-1:0] : ras_pick[BA_WIDTH-1:0];
        gnt_nxt   = (gnt_idx == BA_WIDTH'(BK_CNT - 1)) ? '0 : gnt_idx + 1'b1;
        gnt_type  = req_cmd[2*gnt_idx +: 2];
        gnt_addr  = req_addr[ADDR_WIDTH*gnt_idx +: ADDR_WIDTH];
        req_ready = gnt_valid ? (BK_CNT'(1) << gnt_idx) : '0;
    end

    always_comb begin
        ccd_d       = (ccd_q != '0) ? ccd_q - 1'b1 : '0;
        rd_blk_d    = (rd_blk_q != '0) ? rd_blk_q - 1'b1 : '0;
        wr_blk_d    = (wr_blk_q != '0) ? wr_blk_q - 1'b1 : '0;
        cas_ptr_d   = cas_ptr_q;
        ras_ptr_d   = ras_ptr_q;
        cmd_valid_d = gnt_valid;
        cmd_type_d  = cmd_type_q;
        cmd_ba_d    = cmd_ba_q;
        cmd_addr_d  = cmd_addr_q;
        if (gnt_valid) begin
            cmd_type_d = gnt_type;
            cmd_ba_d   = gnt_idx;
            cmd_addr_d = gnt_addr;
            if (gnt_cas) begin
                cas_ptr_d = gnt_nxt;
                ccd_d     = CW'(TCCD - 1);
                if (gnt_type == CMD_RD) begin
                    wr_blk_d = CW'(TRTW - 1);
                end else begin
                    rd_blk_d = CW'(TWTR - 1);
                end
            end else begin
                ras_ptr_d = gnt_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ccd_q       <= '0;
            rd_blk_q    <= '0;
            wr_blk_q    <= '0;
            cas_ptr_q   <= '0;
            ras_ptr_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= '0;
            cmd_ba_q    <= '0;
            cmd_addr_q  <= '0;
        end else begin
            ccd_q       <= ccd_d;
            rd_blk_q    <= rd_blk_d;
            wr_blk_q    <= wr_blk_d;
            cas_ptr_q   <= cas_ptr_d;
            ras_ptr_q   <= ras_ptr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_type_q  <= cmd_type_d;
            cmd_ba_q    <= cmd_ba_d;
            cmd_addr_q  <= cmd_addr_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_type  = cmd_type_q;
    assign cmd_ba    = cmd_ba_q;
    assign cmd_addr  = cmd_addr_q;

endmodule

// File: tb/tb_sal_cmd_sched.sv
// Randomized and directed bench for sal_cmd_sched against a timestamp-based scheduling model.
module tb_sal_cmd_sched;

    localparam int N    = 4;
    localparam int BW   = 2;
    localparam int AW   = 16;
    localparam int TCCD = 4;
    localparam int TRTW = 6;
    localparam int TWTR = 8;
    localparam longint NONE = -1000;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [2*N-1:0]  req_cmd;
    logic [AW*N-1:0] req_addr;
    logic [N-1:0]    req_ready;
    logic            cmd_valid;
    logic [1:0]      cmd_type;
    logic [BW-1:0]   cmd_ba;
    logic [AW-1:0]   cmd_addr;

    sal_cmd_sched #(
        .BK_CNT(N), .BA_WIDTH(BW), .ADDR_WIDTH(AW),
        .TCCD(TCCD), .TRTW(TRTW), .TWTR(TWTR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr),
        .req_ready(req_ready),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_ba(cmd_ba), .cmd_addr(cmd_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Bank-side pending requests and model state.
    bit          pend_v[N];
    logic [1:0]  pend_cmd[N];
    logic [15:0] pend_addr[N];
    longint      cyc, last_rd, last_wr, last_cas;
    int          cas_ptr, ras_ptr;
    logic        exp_v;
    logic [1:0]  exp_type;
    logic [1:0]  exp_ba;
    logic [15:0] exp_addr;
    int          refill_mode;   // 0 none, 1 re-arm granted bank, 2 random new requests
    int          refill_pct;
    int          log_bank[$];
    longint      log_cyc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        cyc      = 0;
        last_rd  = NONE;
        last_wr  = NONE;
        last_cas = NONE;
        cas_ptr  = 0;
        ras_ptr  = 0;
        exp_v    = 1'b0;
        exp_type = '0;
        exp_ba   = '0;
        exp_addr = '0;
        log_bank.delete();
        log_cyc.delete();
    endtask

    task automatic clear_pend();
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    endtask

    task automatic set_pend(input int b, input logic [1:0] c, input logic [15:0] a);
        pend_v[b]    = 1'b1;
        pend_cmd[b]  = c;
        pend_addr[b] = a;
    endtask

    // One cycle, entered at a negedge: check registered outputs, drive, check grant, advance model.
    task automatic step_body();
        int  g;
        int  idx;
        bit  found;
        bit  is_cas;
        bit  rd_ok, wr_ok;
        logic [N-1:0] er;
        chk("cmd_valid", 32'(cmd_valid), 32'(exp_v));
        chk("cmd_type", 32'(cmd_type), 32'(exp_type));
        chk("cmd_ba", 32'(cmd_ba), 32'(exp_ba));
        chk("cmd_addr", 32'(cmd_addr), 32'(exp_addr));
        for (int i = 0; i < N; i++) begin
            req_valid[i] = pend_v[i];
            req_cmd[2*i +: 2]   = pend_v[i] ? pend_cmd[i] : 2'($urandom);
            req_addr[AW*i +: AW] = pend_v[i] ? pend_addr[i] : 16'($urandom);
        end
        #1;
        rd_ok = (cyc - last_cas >= TCCD) && (cyc - last_wr >= TWTR);
        wr_ok = (cyc - last_cas >= TCCD) && (cyc - last_rd >= TRTW);
        found = 1'b0;
        is_cas = 1'b0;
        g = 0;
        for (int k = 0; k < N; k++) begin
            idx = (cas_ptr + k) % N;
            if (!found && pend_v[idx] &&
                ((pend_cmd[idx] == 2'd1 && rd_ok) || (pend_cmd[idx] == 2'd2 && wr_ok))) begin
                found = 1'b1;
                is_cas = 1'b1;
                g = idx;
            end
        end
        for (int k = 0; k < N; k++) begin
            idx = (ras_ptr + k) % N;
            if (!found && pend_v[idx] && (pend_cmd[idx] == 2'd0 || pend_cmd[idx] == 2'd3)) begin
                found = 1'b1;
                g = idx;
            end
        end
        er = found ? N'(1 << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(er));
        exp_v = found;
        if (found) begin
            exp_type = pend_cmd[g];
            exp_ba   = 2'(g);
            exp_addr = pend_addr[g];
            log_bank.push_back(g);
            log_cyc.push_back(cyc);
            if (is_cas) begin
                cas_ptr  = (g + 1) % N;
                last_cas = cyc;
                if (pend_cmd[g] == 2'd1) last_rd = cyc;
                else last_wr = cyc;
            end else begin
                ras_ptr = (g + 1) % N;
            end
            pend_v[g] = 1'b0;
            if (refill_mode == 1) pend_v[g] = 1'b1;
        end
        if (refill_mode == 2) begin
            for (int i = 0; i < N; i++) begin
                if (!pend_v[i] && $urandom_range(99) < refill_pct)
                    set_pend(i, 2'($urandom), 16'($urandom));
            end
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        step_body();
    endtask

    // Holds reset for n cycles, then releases it and runs the first post-reset cycle (cycle 0).
    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_valid", 32'(cmd_valid), 32'd0);
        chk("rst_addr", 32'(cmd_addr), 32'd0);
        chk("rst_ba", 32'(cmd_ba), 32'd0);
        chk("rst_type", 32'(cmd_type), 32'd0);
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            chk("rst_hold_valid", 32'(cmd_valid), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        step_body();
    endtask

    task automatic chk_log(input string tag, input int k, input int b, input longint c);
        chk({tag, "_bank"}, 32'(log_bank.size() > k ? log_bank[k] : -1), 32'(b));
        chk({tag, "_cyc"}, 32'(log_cyc.size() > k ? log_cyc[k] : -1), 32'(c));
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_cmd = '0;
        req_addr = '0;
        refill_mode = 0;
        refill_pct = 0;
        clear_pend();
        model_clear();

        // Single ACT on bank 2.
        set_pend(2, 2'd0, 16'h1234);
        do_reset(2);
        step();
        step();
        chk("t1_count", 32'(log_bank.size()), 32'd1);
        chk_log("t1", 0, 2, 0);

        // Continuous RD from banks 0, 1, 3: one grant every TCCD.
        clear_pend();
        refill_mode = 1;
        set_pend(0, 2'd1, 16'h0010);
        set_pend(1, 2'd1, 16'h0011);
        set_pend(3, 2'd1, 16'h0013);
        do_reset(2);
        repeat (12) step();
        chk_log("t2a", 0, 0, 0);
        chk_log("t2b", 1, 1, 4);
        chk_log("t2c", 2, 3, 8);
        chk_log("t2d", 3, 0, 12);

        // RD, then ACT fills the gap, WR after tRTW, later RD after tWTR.
        clear_pend();
        refill_mode = 0;
        set_pend(0, 2'd1, 16'h0100);
        set_pend(1, 2'd2, 16'h0101);
        set_pend(2, 2'd0, 16'h0102);
        do_reset(2);
        repeat (6) step();
        set_pend(0, 2'd1, 16'h0200);
        repeat (8) step();
        chk_log("t3a", 0, 0, 0);
        chk_log("t3b", 1, 2, 1);
        chk_log("t3c", 2, 1, 6);
        chk_log("t3d", 3, 0, 14);

        // CAS beats RAS in the same cycle.
        clear_pend();
        set_pend(0, 2'd3, 16'h0300);
        set_pend(3, 2'd1, 16'h0303);
        do_reset(2);
        step();
        step();
        chk_log("t4a", 0, 3, 0);
        chk_log("t4b", 1, 0, 1);

        // Reset after a WR clears turnaround: pending RD goes on the release cycle.
        clear_pend();
        set_pend(0, 2'd2, 16'h0400);
        set_pend(1, 2'd1, 16'h0401);
        do_reset(2);
        step();
        do_reset(2);
        chk_log("t5", 0, 1, 0);
        step();

        // All banks ACT continuously: strict rotation.
        clear_pend();
        refill_mode = 1;
        for (int i = 0; i < N; i++) set_pend(i, 2'd0, 16'(16'h0600 + i));
        do_reset(2);
        repeat (5) step();
        chk_log("t6a", 0, 0, 0);
        chk_log("t6b", 1, 1, 1);
        chk_log("t6c", 2, 2, 2);
        chk_log("t6d", 3, 3, 3);
        chk_log("t6e", 4, 0, 4);

        // Random traffic with occasional mid-stream resets.
        clear_pend();
        refill_mode = 2;
        for (int r = 0; r < 4; r++) begin
            refill_pct = 20 + 25 * r;
            do_reset(1 + r);
            repeat (700) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sal_cmd_sched.md
Name: sal_cmd_sched

Overview:
- Command-bus scheduler between the per-bank controllers and the single DRAM command slot.
- Each cycle it selects at most one pending bank command (ACT/RD/WR/PRE).
- Column commands (RD/WR) have priority over row commands (ACT/PRE).
- Inter-command timing enforced here: tCCD and bus turnaround. Grants use round-robin within each class; the selected command is registered onto the command bus.

Parameters:
- BK_CNT, 4, number of bank controllers (requesters).
- BA_WIDTH, 2, bank address width; equals clog2(BK_CNT).
- ADDR_WIDTH, 16, row or column address field width.
- TCCD, 4, minimum cycles between any two column commands (>=1).
- TRTW, 6, minimum cycles from RD grant to next WR grant (>=1).
- TWTR, 8, minimum cycles from WR grant to next RD grant (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  BK_CNT  per-bank command request
- req_cmd  in  2*BK_CNT  per-bank command; 0=ACT, 1=RD, 2=WR, 3=PRE
- req_addr  in  ADDR_WIDTH*BK_CNT  per-bank row (ACT) or column (RD/WR) address; ignored for PRE
- req_ready  out  BK_CNT  one-hot grant, combinational, same cycle as acceptance
- cmd_valid  out  1  registered command-bus valid
- cmd_type  out  2  registered command encoding
- cmd_ba  out  BA_WIDTH  bank index of the granted requester
- cmd_addr  out  ADDR_WIDTH  registered address

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low (rst_n).
  - Reset values: cmd_valid=0, cmd_type=0, cmd_ba=0, cmd_addr=0.
  - All timing counters = 0; both round-robin pointers = 0.
- Handshake: a bank holds req_valid and its fields stable until req_ready. The transfer occurs when req_valid[i] && req_ready[i]. The scheduler has no request buffer.
- req_ready:
  - At most one bit is set per cycle.
  - It is never set for a bank whose req_valid=0.
  - It is a function of the current inputs and the registered state only.
- Eligibility:
  - RD is eligible iff ccd_cnt==0 && rd_blk==0.
  - WR is eligible iff ccd_cnt==0 && wr_blk==0.
  - ACT and PRE are always eligible. Bank-level timing (tRCD, tRP) belongs to the bank controllers.
- Selection:
  - If any eligible CAS exists, grant the first eligible CAS at or after cas_ptr (circular search). Otherwise grant the first valid RAS at or after ras_ptr.
  - A class pointer updates to (granted index + 1) mod BK_CNT only on a grant in that class.
- Counters, on a grant at cycle t:
  - RD grant: ccd_cnt<=TCCD-1, wr_blk<=TRTW-1.
  - WR grant: ccd_cnt<=TCCD-1, rd_blk<=TWTR-1.
  - Otherwise each nonzero counter decrements by 1 per cycle and saturates at 0.
  - Loading takes precedence over decrementing.
  - Result: the next RD/WR becomes eligible at cycle t+max(TCCD, turnaround), with no extra bubble. A value of 1 means no restriction.
  - Counter width: clog2(max(TCCD,TRTW,TWTR)).
- Output register: one-cycle latency.
  - Grant at t: at t+1, cmd_valid=1 and cmd_type/ba/addr hold the granted fields.
  - Cycle with no grant: cmd_valid=0 at t+1; cmd_type/ba/addr keep their previous values.
- Boundaries:
  - If all pending CAS are blocked, RAS is granted in that cycle, filling the gap.
  - CAS keeps absolute priority, so RAS can starve under continuous eligible CAS. This is accepted.
  - A bank that drops req_valid without a grant is a protocol violation and is not checked.
- Reset mid-operation: outputs, counters and pointers clear immediately. A CAS is grantable on the first cycle after reset release.

Test Plan:
1. Bank2 ACT, addr=0x1234, at cycle 0, all else idle -> req_ready=4'b0100 at cycle 0; cmd_valid=1, cmd_type=0, cmd_ba=2, cmd_addr=0x1234 at cycle 1; cmd_valid=0 at cycle 2.
2. Banks 0, 1 and 3 hold RD continuously, re-requesting after each grant -> grants to banks 0, 1, 3, 0 at cycles 0, 4, 8, 12; req_ready=0 in the cycles between.
3. Bank0 RD at cycle 0; bank1 WR and bank2 ACT pending from cycle 0 -> RD granted at cycle 0, ACT at cycle 1, WR at cycle 6 (TRTW). A subsequent bank0 RD is granted at cycle 14 (TWTR=8).
4. Bank0 PRE and bank3 RD both valid at cycle 0 with counters idle -> RD (bank3) granted at cycle 0, PRE at cycle 1; ras_ptr=1 and cas_ptr=0 afterwards.
5. WR granted at cycle 0, rst_n low at cycle 2 and released at cycle 4, bank1 RD pending -> cmd_valid=0 during reset; RD granted on the first cycle after release, not held off by TWTR.
6. Round-robin fairness: all 4 banks ACT continuously, no CAS -> grant order 0, 1, 2, 3, 0, one per cycle, cmd_valid high every cycle.
